addx_issue_buffer: RTL and testbench
====================================

# addx_issue_buffer

Decoupling stage that sits directly upstream of the ADDX saturating-add accelerator. It accepts ADDX operations from the issue stage with a valid/ready handshake and queues them in a small FIFO. It drives the accelerator's combinational operand inputs from the FIFO head, registers the result together with its transaction ID and an overflow flag, and presents that to the writeback arbiter with a second valid/ready handshake.

## Interface
Parameters:
- XLEN, 64: operand/result width, 32 or 64.
- TRANS_ID_BITS, 3: scoreboard transaction-ID width.
- DEPTH, 2: FIFO entries; power of two, at least 2.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- flush_i, in, 1: synchronous pipeline flush.
- issue_valid_i, in, 1: ADDX operation offered.
- issue_ready_o, out, 1: buffer can accept.
- operand_a_i, in, XLEN: rs1 value.
- operand_b_i, in, XLEN: rs2 value.
- trans_id_i, in, TRANS_ID_BITS: scoreboard ID.
- accel_operand_a_o, out, XLEN: to accelerator; equals the FIFO head operand A, or 0 when empty.
- accel_operand_b_o, out, XLEN: to accelerator; equals the FIFO head operand B, or 0 when empty.
- accel_valid_o, out, 1: a head entry is being dispatched this cycle.
- accel_result_i, in, XLEN: combinational accelerator result.
- wb_valid_o, out, 1: writeback data valid.
- wb_ready_i, in, 1: arbiter accepts writeback.
- wb_result_o, out, XLEN: registered result.
- wb_trans_id_o, out, TRANS_ID_BITS: registered ID.
- wb_overflow_o, out, 1: the operation saturated.
- op_count_o, out, 32: completed writebacks.
- sat_count_o, out, 32: completed writebacks with wb_overflow_o set.

## Operation
- Push:
  - issue_ready_o = (count < DEPTH), using the registered count only. There is no same-cycle pop bypass.
  - A push occurs when issue_valid_i && issue_ready_o. It writes {a, b, id} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Output register state:
  - EMPTY (wb_valid_o=0) or FULL (wb_valid_o=1).
  - The register is free when EMPTY, or when FULL && wb_ready_i (drain and refill in the same cycle).
- Dispatch:
  - When count > 0 and the register is free, assert accel_valid_o.
  - Pop the head (rd_ptr wraps modulo DEPTH).
  - Capture accel_result_i, the head ID, and the overflow flag; the register goes FULL.
- Overflow flag: (a[XLEN-1] == b[XLEN-1]) && ((a+b)[XLEN-1] != a[XLEN-1]), computed on the head operands with XLEN-bit wrapping add.
- Drain: FULL && wb_ready_i with no dispatch goes to EMPTY. wb_* outputs stay stable while wb_valid_o=1 and wb_ready_i=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Counters:
  - op_count_o increments on each wb_valid_o && wb_ready_i.
  - sat_count_o increments on each wb_valid_o && wb_ready_i && wb_overflow_o.
  - Both wrap modulo 2^32.
  - Neither is cleared by flush.
- Flush:
  - Sets count, wr_ptr and rd_ptr to 0 and the register to EMPTY.
  - Suppresses any same-cycle push, dispatch, or counter increment.
  - Overrides all other events.
- Reset (asynchronous):
  - Outputs: issue_ready_o=1, accel_valid_o=0, accel_operand_a_o=0, accel_operand_b_o=0, wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0, wb_overflow_o=0, op_count_o=0, sat_count_o=0.
  - Internal state: count=0, wr_ptr=0, rd_ptr=0, register EMPTY.
  - Reset mid-operation discards all queued and pending results.

## Timing
- Push accepted at edge E0 → head visible and dispatched in cycle E0+1 → wb_valid_o=1 from E0+2. Latency is 2 cycles.
- Throughput is 1 operation per cycle while wb_ready_i=1: with DEPTH ≥ 2, count never reaches DEPTH in steady state.
- Backpressure (wb_ready_i=0): the register holds, the FIFO fills, and issue_ready_o drops in the cycle after count reaches DEPTH.
  - Example: with DEPTH=2, at most 3 operations are in flight (2 queued plus 1 in the register).
- After wb_ready_i returns high, the next result appears on wb_* in the following cycle, giving back-to-back completion.
- Order: results leave strictly in issue order.

## Test plan
- Single op, XLEN=64: a=5, b=7, id=3, wb_ready_i=1 held → wb_valid_o exactly 2 cycles after acceptance; wb_result_o=12, wb_trans_id_o=3, wb_overflow_o=0; op_count_o=1.
- Saturation, XLEN=32: a=0x7FFFFFFF, b=1 → wb_result_o=0x7FFFFFFF, wb_overflow_o=1, sat_count_o=1. Then a=0x80000000, b=0xFFFFFFFF → wb_result_o=0x80000000, wb_overflow_o=1, sat_count_o=2.
- Backpressure: wb_ready_i=0; issue ids 0..4 continuously → ids 0,1,2 accepted and issue_ready_o low from the 4th cycle. Release wb_ready_i → ids 0,1,2 complete on consecutive cycles, then 3 and 4, in order.
- Streaming: 16 back-to-back ops with wb_ready_i=1 → 16 consecutive wb_valid_o cycles, no bubbles; op_count_o=16.
- Flush with a full FIFO, a pending result, and issue_valid_i=1 in the same cycle → the next cycle has wb_valid_o=0, issue_ready_o=1, and no results emerge; counters unchanged.
- Assert rst_ni low asynchronously mid-stream → all outputs at reset values before the next clock edge; operation resumes normally after release.

Source files
------------

// File: rtl/addx_issue_buffer.sv
// Issue buffer in front of the ADDX saturating-add accelerator: a small operand FIFO,
// a one-entry result register toward writeback, and completion/saturation counters.
module addx_issue_buffer #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          accel_operand_a_o,
  output logic [XLEN-1:0]          accel_operand_b_o,
  output logic                     accel_valid_o,
  input  logic [XLEN-1:0]          accel_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_overflow_o,
  output logic [31:0]              op_count_o,
  output logic [31:0]              sat_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  logic [XLEN-1:0]          r_mem_a  [DEPTH];
  logic [XLEN-1:0]          r_mem_b  [DEPTH];
  logic [TRANS_ID_BITS-1:0] r_mem_id [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  wb_state_e                r_wb_state;
  wb_state_e                w_wb_state_nxt;
  logic [XLEN-1:0]          r_wb_result;
  logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
  logic                     r_wb_overflow;
  logic [31:0]              r_op_count;
  logic [31:0]              r_sat_count;

  logic                     w_not_empty;
  logic                     w_issue_ready;
  logic                     w_push;
  logic                     w_dispatch;
  logic                     w_complete;
  logic                     w_overflow;
  logic [XLEN-1:0]          w_head_a;
  logic [XLEN-1:0]          w_head_b;
  logic [TRANS_ID_BITS-1:0] w_head_id;

  assign w_head_a      = r_mem_a[r_rd_ptr];
  assign w_head_b      = r_mem_b[r_rd_ptr];
  assign w_head_id     = r_mem_id[r_rd_ptr];
  assign w_not_empty   = (r_count != '0);
  // Ready looks only at the registered count; a same-cycle pop never frees a slot early.
  assign w_issue_ready = (r_count < CNT_W'(DEPTH));
  assign w_push        = issue_valid_i && w_issue_ready && !flush_i;
  assign w_complete    = (r_wb_state == WB_FULL) && wb_ready_i && !flush_i;

  // Signed overflow of the wrapping sum, judged from the head operands' sign bits.
  assign w_overflow = (w_head_a[XLEN-1] == w_head_b[XLEN-1]) &&
                      (1'((w_head_a + w_head_b) >> (XLEN - 1)) != w_head_a[XLEN-1]);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_wb_state_nxt = r_wb_state;
    w_dispatch     = 1'b0;
    if (flush_i) begin
      w_wb_state_nxt = WB_EMPTY;
    end else begin
      if (w_not_empty && ((r_wb_state == WB_EMPTY) || wb_ready_i)) begin
        w_dispatch = 1'b1;
      end
      if (w_dispatch) begin
        w_wb_state_nxt = WB_FULL;
      end else if ((r_wb_state == WB_FULL) && wb_ready_i) begin
        w_wb_state_nxt = WB_EMPTY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_state <= WB_EMPTY;
    end else begin
      r_wb_state <= w_wb_state_nxt;
    end
  end

  // NOTE: payload storage has no reset; an entry is only read while r_count marks it live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= operand_a_i;
      r_mem_b[r_wr_ptr]  <= operand_b_i;
      r_mem_id[r_wr_ptr] <= trans_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_dispatch) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_dispatch})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload only moves on dispatch, so it stays stable while writeback stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_result   <= '0;
      r_wb_trans_id <= '0;
      r_wb_overflow <= 1'b0;
    end else if (w_dispatch) begin
      r_wb_result   <= accel_result_i;
      r_wb_trans_id <= w_head_id;
      r_wb_overflow <= w_overflow;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op_count  <= '0;
      r_sat_count <= '0;
    end else if (w_complete) begin
      r_op_count <= r_op_count + 32'd1;
      if (r_wb_overflow) begin
        r_sat_count <= r_sat_count + 32'd1;
      end
    end
  end

  assign issue_ready_o     = w_issue_ready;
  assign accel_valid_o     = w_dispatch;
  assign accel_operand_a_o = w_not_empty ? w_head_a : '0;
  assign accel_operand_b_o = w_not_empty ? w_head_b : '0;
  assign wb_valid_o        = (r_wb_state == WB_FULL);
  assign wb_result_o       = r_wb_result;
  assign wb_trans_id_o     = r_wb_trans_id;
  assign wb_overflow_o     = r_wb_overflow;
  assign op_count_o        = r_op_count;
  assign sat_count_o       = r_sat_count;

endmodule

// File: tb/tb_addx_issue_buffer.sv
// Bench for addx_issue_buffer: a 64-bit instance checked by an in-order scoreboard,
// plus a 32-bit instance for the saturation corner cases.
module tb_addx_issue_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance
  logic        flush = 1'b0, issue_valid = 1'b0, issue_ready;
  logic [63:0] opa = '0, opb = '0, acc_a, acc_b, acc_res, wb_result;
  logic [2:0]  tid = '0, wb_id;
  logic        acc_valid, wb_valid, wb_ready = 1'b1, wb_ovf;
  logic [31:0] op_cnt, sat_cnt;

  // 32-bit instance
  logic        issue_valid_s = 1'b0, issue_ready_s;
  logic [31:0] opa_s = '0, opb_s = '0, acc_a_s, acc_b_s, acc_res_s, wb_result_s;
  logic [2:0]  tid_s = '0, wb_id_s;
  logic        acc_valid_s, wb_valid_s, wb_ovf_s;
  logic [31:0] op_cnt_s, sat_cnt_s;

  int total = 0;
  int bad   = 0;

  function automatic logic ovf64(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    s = a + b;
    return (a[63] == b[63]) && (s[63] != a[63]);
  endfunction

  function automatic logic [63:0] sat64(input logic [63:0] a, input logic [63:0] b);
    if (ovf64(a, b)) return a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return a + b;
  endfunction

  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31])) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s;
  endfunction

  // Behavioural saturating adders standing in for the accelerator.
  assign acc_res   = sat64(acc_a, acc_b);
  assign acc_res_s = sat32(acc_a_s, acc_b_s);

  addx_issue_buffer #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .operand_a_i(opa), .operand_b_i(opb), .trans_id_i(tid),
    .accel_operand_a_o(acc_a), .accel_operand_b_o(acc_b), .accel_valid_o(acc_valid),
    .accel_result_i(acc_res),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
    .wb_trans_id_o(wb_id), .wb_overflow_o(wb_ovf),
    .op_count_o(op_cnt), .sat_count_o(sat_cnt)
  );

  addx_issue_buffer #(.XLEN(32), .TRANS_ID_BITS(3), .DEPTH(2)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .issue_valid_i(issue_valid_s), .issue_ready_o(issue_ready_s),
    .operand_a_i(opa_s), .operand_b_i(opb_s), .trans_id_i(tid_s),
    .accel_operand_a_o(acc_a_s), .accel_operand_b_o(acc_b_s), .accel_valid_o(acc_valid_s),
    .accel_result_i(acc_res_s),
    .wb_valid_o(wb_valid_s), .wb_ready_i(1'b1), .wb_result_o(wb_result_s),
    .wb_trans_id_o(wb_id_s), .wb_overflow_o(wb_ovf_s),
    .op_count_o(op_cnt_s), .sat_count_o(sat_cnt_s)
  );

  // Scoreboard: expectations pushed on accepted issue, popped on writeback handshake.
  typedef struct {
    logic [63:0] res;
    logic [2:0]  id;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   exp_ops = 0;
  int   exp_sat = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_ops = 0;
      exp_sat = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        total++;
        exp_ops++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected: got id=%0d result=%h, expected no writeback", wb_id, wb_result);
        end else begin
          e = sb.pop_front();
          if (e.ovf) exp_sat++;
          if ({wb_result, wb_id, wb_ovf} !== {e.res, e.id, e.ovf}) begin
            bad++;
            $display("FAIL wb_data: got result=%h id=%0d ovf=%b, expected result=%h id=%0d ovf=%b",
                     wb_result, wb_id, wb_ovf, e.res, e.id, e.ovf);
          end
        end
      end
      if (issue_valid && issue_ready) begin
        e.res = sat64(opa, opb);
        e.id  = tid;
        e.ovf = ovf64(opa, opb);
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op to the 64-bit instance and hold it until accepted (bounded).
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] id);
    bit ok = 1'b0;
    issue_valid = 1'b1;
    opa = a;
    opb = b;
    tid = id;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (issue_ready) ok = 1'b1;
      tick();
    end
    issue_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL issue_timeout: got no accept for id=%0d, expected accept within 50 cycles", id);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (!wb_valid && sb.size() == 0) ok = 1'b1;
    end
    tick();
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({issue_ready, acc_valid, acc_a, acc_b, wb_valid, wb_result, wb_id, wb_ovf, op_cnt, sat_cnt}
        !== {1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 3'd0, 1'b0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset64: got ready=%b aval=%b wbv=%b res=%h id=%0d ops=%0d sats=%0d, expected 1 0 0 0 0 0 0",
               issue_ready, acc_valid, wb_valid, wb_result, wb_id, op_cnt, sat_cnt);
    end
    total++;
    if ({issue_ready_s, acc_valid_s, acc_a_s, acc_b_s, wb_valid_s, wb_result_s, op_cnt_s, sat_cnt_s}
        !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset32: got ready=%b wbv=%b res=%h, expected 1 0 0", issue_ready_s, wb_valid_s, wb_result_s);
    end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    wb_ready    = 1'b1;
    issue_valid = 1'b1;
    opa = 64'd5;
    opb = 64'd7;
    tid = 3'd3;
    tick();                       // edge E0: accepted
    issue_valid = 1'b0;
    total++;
    if ({wb_valid, acc_valid, acc_a, acc_b} !== {1'b0, 1'b1, 64'd5, 64'd7}) begin
      bad++;
      $display("FAIL single_dispatch: got wbv=%b aval=%b a=%0d b=%0d, expected 0 1 5 7",
               wb_valid, acc_valid, acc_a, acc_b);
    end
    tick();                       // edge E0+1: captured
    total++;
    if ({wb_valid, wb_result, wb_id, wb_ovf} !== {1'b1, 64'd12, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL single_result: got v=%b res=%0d id=%0d ovf=%b, expected 1 12 3 0",
               wb_valid, wb_result, wb_id, wb_ovf);
    end
    tick();
    total++;
    if ({wb_valid, op_cnt} !== {1'b0, 32'd1}) begin
      bad++;
      $display("FAIL single_count: got v=%b ops=%0d, expected 0 1", wb_valid, op_cnt);
    end
  endtask

  task automatic test_saturation32();
    logic [31:0] a_tab [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] b_tab [2] = '{32'h0000_0001, 32'hFFFF_FFFF};
    logic [31:0] r_tab [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
    for (int k = 0; k < 2; k++) begin
      issue_valid_s = 1'b1;
      opa_s = a_tab[k];
      opb_s = b_tab[k];
      tid_s = 3'(k + 1);
      tick();
      issue_valid_s = 1'b0;
      tick();
      total++;
      if ({wb_valid_s, wb_result_s, wb_ovf_s, wb_id_s} !== {1'b1, r_tab[k], 1'b1, 3'(k + 1)}) begin
        bad++;
        $display("FAIL sat32_%0d: got v=%b res=%h ovf=%b id=%0d, expected 1 %h 1 %0d",
                 k, wb_valid_s, wb_result_s, wb_ovf_s, wb_id_s, r_tab[k], k + 1);
      end
      tick();
      total++;
      if (sat_cnt_s !== 32'(k + 1)) begin
        bad++;
        $display("FAIL sat32_count_%0d: got %0d, expected %0d", k, sat_cnt_s, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int          accepted = 0;
    logic [63:0] held_res;
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      issue_valid = 1'b1;
      opa = 64'(100 * (accepted + 1));
      opb = 64'(accepted);
      tid = 3'(accepted);
      @(negedge clk);
      total++;
      if (issue_ready !== (c < 3)) begin
        bad++;
        $display("FAIL bp_ready_cycle%0d: got %b, expected %b", c, issue_ready, c < 3);
      end
      if (issue_ready) accepted++;
      tick();
    end
    issue_valid = 1'b0;
    held_res = wb_result;
    tick();
    total++;
    if ({wb_valid, wb_id, wb_result} !== {1'b1, 3'd0, held_res}) begin
      bad++;
      $display("FAIL bp_hold: got v=%b id=%0d res=%h, expected 1 0 %h", wb_valid, wb_id, wb_result, held_res);
    end
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({wb_valid, wb_id} !== {1'b1, 3'(k)}) begin
        bad++;
        $display("FAIL bp_release_%0d: got v=%b id=%0d, expected 1 %0d", k, wb_valid, wb_id, k);
      end
      tick();
    end
    issue(64'd400, 64'd3, 3'd3);
    issue(64'd500, 64'd4, 3'd4);
    drain();
  endtask

  task automatic test_streaming();
    logic [31:0] start = op_cnt;
    int run = 0;
    int max_run = 0;
    int not_ready = 0;
    wb_ready = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc < 16) begin
        issue_valid = 1'b1;
        opa = (cyc % 4 == 0) ? 64'h7FFF_FFFF_FFFF_FFF0 : {$urandom, $urandom};
        opb = (cyc % 4 == 0) ? 64'h0000_0000_0000_0100 : {$urandom, $urandom};
        tid = 3'(cyc);
      end else begin
        issue_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 16 && issue_ready !== 1'b1) not_ready++;
      if (wb_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
    end
    total++;
    if (not_ready != 0) begin
      bad++;
      $display("FAIL stream_ready: got %0d stalled issue cycles, expected 0", not_ready);
    end
    total++;
    if (max_run != 16) begin
      bad++;
      $display("FAIL stream_run: got %0d consecutive valid cycles, expected 16", max_run);
    end
    total++;
    if (op_cnt - start !== 32'd16) begin
      bad++;
      $display("FAIL stream_count: got %0d completions, expected 16", op_cnt - start);
    end
    total++;
    if ({op_cnt, sat_cnt} !== {32'(exp_ops), 32'(exp_sat)}) begin
      bad++;
      $display("FAIL stream_counters: got ops=%0d sats=%0d, expected %0d %0d", op_cnt, sat_cnt, exp_ops, exp_sat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ops0, sats0;
    int seen = 0;
    wb_ready = 1'b0;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd5);
    issue(64'd2, 64'd2, 3'd6);
    issue(64'd3, 64'd3, 3'd7);
    ops0  = op_cnt;
    sats0 = sat_cnt;
    wb_ready    = 1'b1;
    issue_valid = 1'b1;
    opa = 64'd9;
    tid = 3'd1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    total++;
    if ({wb_valid, issue_ready, acc_valid, op_cnt, sat_cnt} !== {1'b0, 1'b1, 1'b0, ops0, sats0}) begin
      bad++;
      $display("FAIL flush_state: got v=%b rdy=%b aval=%b ops=%0d sats=%0d, expected 0 1 0 %0d %0d",
               wb_valid, issue_ready, acc_valid, op_cnt, sat_cnt, ops0, sats0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wb_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0 || op_cnt !== ops0) begin
      bad++;
      $display("FAIL flush_quiet: got %0d results ops=%0d, expected 0 results ops=%0d", seen, op_cnt, ops0);
    end
  endtask

  task automatic test_async_reset();
    wb_ready    = 1'b1;
    issue_valid = 1'b1;
    opa = 64'd11;
    opb = 64'd22;
    tid = 3'd2;
    @(posedge clk);
    opa = 64'd33;
    tid = 3'd4;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({issue_ready, acc_valid, acc_a, acc_b, wb_valid, wb_result, wb_id, wb_ovf, op_cnt, sat_cnt}
        !== {1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 3'd0, 1'b0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL async_reset: got ready=%b aval=%b wbv=%b res=%h ops=%0d sats=%0d, expected 1 0 0 0 0 0",
               issue_ready, acc_valid, wb_valid, wb_result, op_cnt, sat_cnt);
    end
    issue_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    issue(64'd40, 64'd2, 3'd6);
    drain();
    total++;
    if ({op_cnt, sat_cnt} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL post_reset_count: got ops=%0d sats=%0d, expected 1 0", op_cnt, sat_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_saturation32();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
